uart_rfifo: RTL

UART_RFIFO -- requirements
Module: uart_rfifo

---
 rtl/uart_rfifo_pkg.sv | 7 +
 rtl/uart_fifo_mem.sv | 18 +
 rtl/uart_rfifo.sv | 78 +++++++
 3 files changed

// File: rtl/uart_rfifo_pkg.sv
// uart_rfifo_pkg: receiver FIFO geometry shared by the FIFO and the register block.
package uart_rfifo_pkg;
    localparam int UART_FIFO_REC_WIDTH = 10;
    localparam int UART_FIFO_DEPTH     = 16;
    localparam int UART_FIFO_POINTER_W = 4;
    localparam int UART_FIFO_COUNTER_W = 5;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: unreset storage array, synchronous write, asynchronous read.
module uart_fifo_mem #(
    parameter int W  = 10,
    parameter int D  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [D];
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_rfifo.sv
// uart_rfifo: UART receive FIFO with per-entry error flags, sticky overrun and show-ahead head output.
module uart_rfifo
    import uart_rfifo_pkg::*;
#(
    parameter int FIFO_WIDTH = UART_FIFO_REC_WIDTH,
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
    parameter int POINTER_W  = UART_FIFO_POINTER_W,
    parameter int COUNTER_W  = UART_FIFO_COUNTER_W
) (
    input  logic                  clk,
    input  logic                  wb_rst_i,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  fifo_reset,
    input  logic                  reset_status,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic [COUNTER_W-1:0]  count,
    output logic                  overrun,
    output logic                  error_bit
);
    logic [POINTER_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [COUNTER_W-1:0]  cnt_q, cnt_d;
    logic [FIFO_DEPTH-1:0] flags_q, flags_d;
    logic                  ovr_q, ovr_d, err_q, err_d;
    logic                  full, empty, do_push, do_pop;
    logic [FIFO_WIDTH-1:0] head;

    assign full    = cnt_q == COUNTER_W'(FIFO_DEPTH);
    assign empty   = cnt_q == '0;
    // A full FIFO still accepts a push when a pop frees the head in the same cycle.
    assign do_push = push & ~fifo_reset & (~full | pop);
    assign do_pop  = pop & ~fifo_reset & ~empty;

    always_comb begin
        rd_d    = fifo_reset ? '0 : do_pop ? rd_q + POINTER_W'(1) : rd_q;
        wr_d    = fifo_reset ? '0 : do_push ? wr_q + POINTER_W'(1) : wr_q;
        cnt_d   = fifo_reset ? '0 : cnt_q + COUNTER_W'(do_push) - COUNTER_W'(do_pop);
        flags_d = flags_q;
        if (do_pop) flags_d[rd_q] = 1'b0;
        if (do_push) flags_d[wr_q] = data_in[1] | data_in[0];
        if (fifo_reset) flags_d = '0;
        err_d   = |flags_d;
        ovr_d   = fifo_reset ? 1'b0 : (push & full & ~pop) ? 1'b1 : reset_status ? 1'b0 : ovr_q;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    uart_fifo_mem #(.W(FIFO_WIDTH), .D(FIFO_DEPTH), .AW(POINTER_W)) u_mem (
        .clk     (clk),
        .we_i    (do_push),
        .waddr_i (wr_q),
        .wdata_i (data_in),
        .raddr_i (rd_q),
        .rdata_o (head)
    );

    assign data_out  = empty ? '0 : head;
    assign count     = cnt_q;
    assign overrun   = ovr_q;
    assign error_bit = err_q;
endmodule
